// File: rtl/result_monitor.sv
// rtl/result_monitor.sv - first-word fall-through result FIFO with saturating overflow/drop counters
module result_monitor #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample,
  input  logic [WIDTH-1:0]     i_value,
  input  logic                 i_overflow,
  input  logic                 i_clear,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_data_ovf,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CNT_WIDTH-1:0] o_ovf_count,
  output logic [CNT_WIDTH-1:0] o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  logic [WIDTH:0]         r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_occ;
  logic [CNT_WIDTH-1:0]   r_ovf_cnt;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  logic w_push;
  logic w_pop;
  logic w_drop;

  assign o_empty = (r_occ == '0);
  assign o_full  = (r_occ == FULL_OCC);
  assign o_valid = !o_empty;

  assign w_pop  = o_valid && i_ready;
  assign w_push = i_sample && (!o_full || w_pop);
  assign w_drop = i_sample && !w_push;

  // Head is read straight from storage so a pushed entry shows one cycle later.
  assign {o_data_ovf, o_data} = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_overflow, i_value};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  // Clear wins over any increment; both counters stick at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (i_clear) begin
      r_ovf_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (i_sample && i_overflow && !(&r_ovf_cnt)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_drop && !(&r_drop_cnt))                r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_ovf_count  = r_ovf_cnt;
  assign o_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_result_monitor.sv
// tb/tb_result_monitor.sv - directed and model-checked bench for result_monitor
module tb_result_monitor;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sample = 1'b0;
  logic [W-1:0]  i_value = '0;
  logic          i_overflow = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_valid, o_data_ovf, o_full, o_empty;
  logic [W-1:0]  o_data;
  logic [CW-1:0] o_ovf_count, o_drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0] mq[$];
  int m_ovf = 0;
  int m_drop = 0;

  result_monitor #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample), .i_value(i_value),
    .i_overflow(i_overflow), .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_data_ovf(o_data_ovf), .o_full(o_full), .o_empty(o_empty),
    .o_ovf_count(o_ovf_count), .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue holding at most D entries plus two saturating integers.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mq.delete();
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      bit pop, push;
      pop  = (mq.size() > 0) && i_ready;
      push = i_sample && ((mq.size() < D) || pop);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({i_overflow, i_value});
      if (i_clear) begin
        m_ovf  = 0;
        m_drop = 0;
      end else begin
        if (i_sample && i_overflow && m_ovf < CMAX) m_ovf++;
        if (i_sample && !push && m_drop < CMAX)     m_drop++;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("m_valid", o_valid, mq.size() > 0);
      chk("m_empty", o_empty, mq.size() == 0);
      chk("m_full",  o_full,  mq.size() == D);
      chk("m_ovf_count",  o_ovf_count,  m_ovf);
      chk("m_drop_count", o_drop_count, m_drop);
      if (mq.size() > 0) begin
        chk("m_data",     o_data,     mq[0][W-1:0]);
        chk("m_data_ovf", o_data_ovf, mq[0][W]);
      end
    end
  end

  task automatic cyc(input bit s, input logic [W-1:0] v, input bit ov, input bit rdy, input bit clr);
    i_sample = s; i_value = v; i_overflow = ov; i_ready = rdy; i_clear = clr;
    @(posedge i_clk);
    #1;
    i_sample = 1'b0; i_overflow = 1'b0; i_clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full",  o_full,  0);
    chk("rst_ovf",   o_ovf_count, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // basic push/pop; first push lands on first edge after reset release
    cyc(1, 32'h5, 0, 1, 0);
    chk("basic_valid", o_valid, 1);
    chk("basic_data",  o_data, 32'h5);
    chk("basic_ovf",   o_data_ovf, 0);
    cyc(0, 0, 0, 1, 0);
    chk("basic_empty", o_empty, 1);

    // fill and drop
    for (int i = 1; i <= 6; i++) begin
      cyc(1, i, 0, 0, 0);
      if (i == 4) chk("fill_full4", o_full, 1);
    end
    chk("fill_drop", o_drop_count, 2);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_seq", o_data, k);
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_empty", o_empty, 1);

    // push and pop together while full
    for (int i = 10; i <= 13; i++) cyc(1, i, 0, 0, 0);
    cyc(1, 14, 0, 1, 0);
    chk("fpp_full", o_full, 1);
    for (int k = 11; k <= 14; k++) begin
      chk("fpp_seq", o_data, k);
      cyc(0, 0, 0, 1, 0);
    end
    chk("fpp_drop", o_drop_count, 2);

    // overflow saturation, drop saturation, then clear with a colliding increment
    for (int i = 0; i < 20; i++) cyc(1, 100 + i, 1, 1, 0);
    chk("sat_ovf", o_ovf_count, 15);
    cyc(1, 200, 1, 1, 0);
    chk("sat_ovf_hold", o_ovf_count, 15);
    for (int i = 0; i < 20; i++) cyc(1, 300 + i, 0, 0, 0);
    chk("sat_drop", o_drop_count, 15);
    cyc(1, 400, 1, 0, 1);
    chk("clr_ovf",  o_ovf_count, 0);
    chk("clr_drop", o_drop_count, 0);
    chk("clr_fifo_full", o_full, 1);
    repeat (4) cyc(0, 0, 0, 1, 0);

    // mixed random traffic against the model
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
    repeat (5) cyc(0, 0, 0, 1, 1);

    // reset mid-operation: 3 entries, one drop
    for (int i = 0; i < 5; i++) cyc(1, 32'hA0 + i, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("pre_rst_drop", o_drop_count, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_empty", o_empty, 1);
    chk("mid_rst_ovf",   o_ovf_count, 0);
    chk("mid_rst_drop",  o_drop_count, 0);
    #1;
    i_rst = 1'b0;
    cyc(1, 32'hDEADBEEF, 0, 0, 0);
    chk("post_rst_head", o_data, 32'hDEADBEEF);
    chk("post_rst_valid", o_valid, 1);
    cyc(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
